// File: rtl/input_mapper_if.sv
// Serial-bit input and decoded-frame output handshake bundle for input_mapper.
// master = bit source / frame consumer side, slave = the mapper itself.
interface input_mapper_if #(
  parameter int CNT_W = 16
) ();
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [2:0]       m_Imin_1;
  logic [2:0]       m_Qmin_1;
  logic [2:0]       m_Imin_2;
  logic [2:0]       m_Qmin_2;
  logic [4:0]       q_min;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output bit_in, bit_valid, out_ready,
    input  bit_ready, m_Imin_1, m_Qmin_1, m_Imin_2, m_Qmin_2, q_min,
           out_valid, frame_cnt
  );

  modport slave (
    input  bit_in, bit_valid, out_ready,
    output bit_ready, m_Imin_1, m_Qmin_1, m_Imin_2, m_Qmin_2, q_min,
           out_valid, frame_cnt
  );
endinterface

// File: rtl/input_mapper.sv
// Collects 12-bit serial frames (8 index bits + 4 group bits, MSB first) and
// decodes them into four Bv indices and a group index behind a one-deep output slot.
//
//   state     | meaning
//   S_COLLECT | shifting in frame bits, bit_ready=1
//   S_FULL    | 12 bits held, waiting for the output slot to free up
module input_mapper #(
  parameter int FRAME_BITS = 12,
  parameter int CNT_W      = 16
) (
  input logic          clk,
  input logic          rst_n,
  input logic          flush,
  input_mapper_if.slave bus
);

  localparam int BC_W = $clog2(FRAME_BITS + 1);

  typedef enum logic {
    S_COLLECT,
    S_FULL
  } state_t;

  state_t                state;
  logic [BC_W-1:0]       bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [CNT_W-1:0]      frame_cnt_q;

  // Inverse Bv map; note the Gray-style ordering of 11 and 10.
  function automatic logic [2:0] bv_inv(input logic [1:0] p);
    logic [2:0] v;
    case (p)
      2'b00:   v = 3'd1;
      2'b01:   v = 3'd2;
      2'b11:   v = 3'd3;
      default: v = 3'd4;
    endcase
    return v;
  endfunction

  logic consume;
  logic slot_free;
  assign consume   = bus.out_valid & bus.out_ready;
  assign slot_free = ~bus.out_valid | bus.out_ready;

  assign bus.frame_cnt = frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_COLLECT;
      bit_cnt       <= '0;
      shreg         <= '0;
      frame_cnt_q   <= '0;
      bus.bit_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.m_Imin_1  <= '0;
      bus.m_Qmin_1  <= '0;
      bus.m_Imin_2  <= '0;
      bus.m_Qmin_2  <= '0;
      bus.q_min     <= '0;
    end else if (flush) begin
      // Anything accepted or consumed this cycle is dropped; the counter keeps its value.
      state         <= S_COLLECT;
      bit_cnt       <= '0;
      bus.bit_ready <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      if (consume) begin
        frame_cnt_q   <= frame_cnt_q + 1'b1;
        bus.out_valid <= 1'b0;
      end

      case (state)
        S_COLLECT: begin
          if (bus.bit_valid) begin
            shreg <= {shreg[FRAME_BITS-2:0], bus.bit_in};
            if (bit_cnt == BC_W'(FRAME_BITS - 1)) begin
              bit_cnt       <= BC_W'(FRAME_BITS);
              state         <= S_FULL;
              bus.bit_ready <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        S_FULL: begin
          // Loading overrides the clear from a same-cycle consume.
          if (slot_free) begin
            bus.m_Imin_1  <= bv_inv(shreg[11:10]);
            bus.m_Qmin_1  <= bv_inv(shreg[9:8]);
            bus.m_Imin_2  <= bv_inv(shreg[7:6]);
            bus.m_Qmin_2  <= bv_inv(shreg[5:4]);
            bus.q_min     <= {1'b0, shreg[3:0]} + 5'd1;
            bus.out_valid <= 1'b1;
            bit_cnt       <= '0;
            state         <= S_COLLECT;
            bus.bit_ready <= 1'b1;
          end
        end

        default: begin
          state         <= S_COLLECT;
          bit_cnt       <= '0;
          bus.bit_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/input_mapper.md
INPUT_MAPPER -- requirements
Module: input_mapper

Interface
REQ-001 Parameter: FRAME_BITS, 12, bits per frame (8 index bits b1 + 4 group bits b2); fixed, other values unsupported.
REQ-002 Parameter: CNT_W, 16, width of delivered-frame counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous clear of partial frame and output slot.
REQ-006 bit_in  input  1  serial data bit, MSB of frame first.
REQ-007 bit_valid  input  1  bit_in valid this cycle.
REQ-008 bit_ready  output  1  block accepts a bit this cycle.
REQ-009 m_Imin_1, m_Qmin_1, m_Imin_2, m_Qmin_2  output  3 each  decoded Bv indices, range 1-4.
REQ-010 q_min  output  5  decoded group index, range 1-16.
REQ-011 out_valid  output  1  decoded frame present.
REQ-012 out_ready  input  1  downstream consumes the frame.
REQ-013 frame_cnt  output  CNT_W  count of delivered frames.

Function
REQ-014 Bit accepted when bit_valid and bit_ready both high at a rising edge; shifted into 12-bit register, bit count incremented.
REQ-015 Frame order: bits 1-8 = b1[7:0], bits 9-12 = b2[3:0], MSB first.
REQ-016 States: COLLECT (count 0-11, bit_ready=1) and FULL (count=12, bit_ready=0).
REQ-017 COLLECT->FULL on acceptance of the 12th bit.
REQ-018 FULL->COLLECT when the output slot is free (out_valid=0, or out_valid=1 and out_ready=1 same cycle): decoded frame loaded, out_valid=1, count=0.
REQ-019 Latency: 12th bit accepted at edge t; out_valid high after edge t+1 when slot free; minimum frame period 13 cycles.
REQ-020 Inverse Bv map per 2-bit pair: 00->1, 01->2, 11->3, 10->4; the four maps are 3-bit values on m_Imin_1=b1[7:6], m_Qmin_1=b1[5:4], m_Imin_2=b1[3:2], m_Qmin_2=b1[1:0].
REQ-021 q_min = zero-extended b2 + 1, 5-bit; b2=15 gives 16, no wrap.
REQ-022 Output slot holds all index/q_min values stable while out_valid=1 and out_ready=0.
REQ-023 out_valid cleared on out_ready=1 unless a new frame loads the same cycle (REQ-018), in which case it stays 1 with new data.
REQ-024 out_ready ignored while out_valid=0.
REQ-025 frame_cnt increments by 1 on each out_valid and out_ready cycle; wraps from 2^CNT_W-1 to 0.
REQ-026 flush=1: count=0, state COLLECT, out_valid=0; bit accepted or frame consumed in the same cycle is discarded and not counted; frame_cnt unchanged.
REQ-027 bit_valid while bit_ready=0 is ignored; the bit is not stored.

Reset
REQ-028 rst_n low asynchronously forces: count=0, COLLECT, shift register=0, out_valid=0, all index outputs=0, q_min=0, frame_cnt=0; bit_ready=1 after release.
REQ-029 Reset asserted mid-frame or with out_valid high discards partial frame and pending output with no further handshake.

Verification
REQ-030 Bits 1011_0100_1111, bit_valid continuous, out_ready=1 -> m_Imin_1=4, m_Qmin_1=3, m_Imin_2=2, m_Qmin_2=1, q_min=16, out_valid one cycle, frame_cnt=1.
REQ-031 Bits 0001_1110_0000 then out_ready=0 for 20 cycles while a second frame is streamed -> first frame (1,2,3,4, q_min=1) held stable; bit_ready=0 once second frame full; second frame appears the cycle after out_ready=1.
REQ-032 bit_valid toggling 1/0 across a frame -> only valid bits counted; decode identical to continuous case.
REQ-033 flush after 7 bits, then full frame 0000_0000_0111 -> indices 1,1,1,1, q_min=8; no corrupted partial frame delivered.
REQ-034 rst_n low after 5 bits and with out_valid high -> all outputs 0 immediately; next full frame decodes correctly, frame_cnt=1.
REQ-035 frame_cnt preset by 65535 delivered frames (CNT_W=16), one more -> frame_cnt=0.
